// File: rtl/eth_mac_extract_if.sv
// Byte-stream bundle between the frame receiver, the MAC extractor and the hasher.
// master drives the received frame bytes and observes results; slave is the extractor side.
interface eth_mac_extract_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11
);
  logic [pDATA_WIDTH-1:0] idata;
  logic                   ivalid;
  logic                   isof;
  logic                   ieof;
  logic [pDATA_WIDTH-1:0] odata;
  logic                   ovalid;
  logic                   osel;
  logic                   olast;
  logic [pLEN_WIDTH-1:0]  oframe_len;
  logic                   olen_valid;
  logic                   oerr;

  modport master (
    output idata, ivalid, isof, ieof,
    input  odata, ovalid, osel, olast, oframe_len, olen_valid, oerr
  );

  modport slave (
    input  idata, ivalid, isof, ieof,
    output odata, ovalid, osel, olast, oframe_len, olen_valid, oerr
  );
endinterface

// File: rtl/eth_mac_extract.sv
// Forwards the dst/src MAC bytes of each frame tagged by field, and reports frame length and malformed frames.
// One cycle from accepted byte to output; applies no backpressure, so every ovalid byte must be taken.
module eth_mac_extract #(
  parameter int pDATA_WIDTH = 8,
  parameter int pMAC_BYTES  = 6,
  parameter int pLEN_WIDTH  = 11
) (
  input  logic             iclk,
  input  logic             irst,
  eth_mac_extract_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DST, SRC, PAYLOAD} state_t;

  localparam logic [pLEN_WIDTH-1:0] DST_LAST = pLEN_WIDTH'(pMAC_BYTES - 1);
  localparam logic [pLEN_WIDTH-1:0] SRC_LAST = pLEN_WIDTH'(2 * pMAC_BYTES - 1);
  localparam logic [pLEN_WIDTH-1:0] LEN_MAX  = '1;
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE  = pLEN_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [pLEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [pDATA_WIDTH-1:0] odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic                   osel_q, osel_d;
  logic                   olast_q, olast_d;
  logic [pLEN_WIDTH-1:0]  len_q, len_d;
  logic                   len_vld_q, len_vld_d;
  logic                   err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    odata_d   = odata_q;
    osel_d    = osel_q;
    ovalid_d  = 1'b0;
    olast_d   = 1'b0;
    len_d     = len_q;
    len_vld_d = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 1'b1;

    if (bus.ivalid) begin
      if (bus.isof) begin
        // A start while a frame is open means the old frame was truncated.
        err_d    = (state_q != IDLE);
        odata_d  = bus.idata;
        ovalid_d = 1'b1;
        osel_d   = 1'b0;
        cnt_d    = LEN_ONE;
        state_d  = DST;
        if (bus.ieof) begin
          err_d     = 1'b1;
          len_vld_d = 1'b1;
          len_d     = LEN_ONE;
          state_d   = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          DST, SRC: begin
            odata_d  = bus.idata;
            ovalid_d = 1'b1;
            osel_d   = (state_q == SRC);
            cnt_d    = cnt_inc;
            olast_d  = (state_q == DST) ? (cnt_q == DST_LAST) : (cnt_q == SRC_LAST);
            if (state_q == DST && cnt_q == DST_LAST) state_d = SRC;
            if (state_q == SRC && cnt_q == SRC_LAST) state_d = PAYLOAD;
            if (bus.ieof) begin
              // Ending anywhere before the last source byte is a runt.
              len_vld_d = 1'b1;
              len_d     = cnt_inc;
              err_d     = !(state_q == SRC && cnt_q == SRC_LAST);
              state_d   = IDLE;
            end
          end
          PAYLOAD: begin
            cnt_d = cnt_inc;
            if (bus.ieof) begin
              len_vld_d = 1'b1;
              len_d     = cnt_inc;
              state_d   = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      osel_q    <= 1'b0;
      olast_q   <= 1'b0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      osel_q    <= osel_d;
      olast_q   <= olast_d;
      len_q     <= len_d;
      len_vld_q <= len_vld_d;
      err_q     <= err_d;
    end
  end

  assign bus.odata      = odata_q;
  assign bus.ovalid     = ovalid_q;
  assign bus.osel       = osel_q;
  assign bus.olast      = olast_q;
  assign bus.oframe_len = len_q;
  assign bus.olen_valid = len_vld_q;
  assign bus.oerr       = err_q;

endmodule

// File: tb/tb_eth_mac_extract.sv
// Bench for eth_mac_extract: frame-level reference model predicts forwarded MAC bytes and length/error reports.
module tb_eth_mac_extract;

  localparam int DW  = 8;
  localparam int MB  = 6;
  localparam int LW  = 11;
  localparam int MAXLEN = (1 << LW) - 1;

  typedef struct packed {
    logic [7:0]  data;
    logic        sel;
    logic        last;
    logic [31:0] cyc;
  } bev_t;

  typedef struct packed {
    logic        err;
    logic        len_vld;
    logic [10:0] len;
    logic [31:0] cyc;
  } sev_t;

  logic iclk;
  logic irst;
  eth_mac_extract_if #(.pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) bus ();

  eth_mac_extract #(.pDATA_WIDTH(DW), .pMAC_BYTES(MB), .pLEN_WIDTH(LW)) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   gap_mode = 0;
  bit   open_frame = 0;
  int   last_len = 0;
  bev_t exp_b[$], obs_b[$];
  sev_t exp_s[$], obs_s[$];

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (!irst) begin
      if (bus.ovalid)
        obs_b.push_back('{data: bus.odata, sel: bus.osel, last: bus.olast, cyc: 32'(cyc)});
      if (bus.olen_valid || bus.oerr)
        obs_s.push_back('{err: bus.oerr, len_vld: bus.olen_valid,
                          len: (bus.olen_valid ? bus.oframe_len : 11'd0), cyc: 32'(cyc)});
    end
  end

  task automatic idle_gaps();
    int g;
    g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(negedge iclk);
      bus.ivalid = 1'b0;
      bus.idata  = 8'($urandom);
      bus.isof   = 1'($urandom);
      bus.ieof   = 1'($urandom);
    end
  endtask

  // Drives one frame and records what the extractor must produce for it.
  task automatic send_frame(input int n, input bit with_eof, input bit rnd, input logic [7:0] base);
    logic [7:0] d;
    int acc, len;
    for (int i = 0; i < n; i++) begin
      idle_gaps();
      @(negedge iclk);
      d = rnd ? 8'($urandom) : base + 8'(i);
      bus.ivalid = 1'b1;
      bus.idata  = d;
      bus.isof   = (i == 0);
      bus.ieof   = with_eof && (i == n - 1);
      acc = cyc + 1;
      if (i == 0 && open_frame)
        exp_s.push_back('{err: 1'b1, len_vld: 1'b0, len: 11'd0, cyc: 32'(acc)});
      if (i < 2 * MB)
        exp_b.push_back('{data: d, sel: (i >= MB), last: (i == MB - 1 || i == 2 * MB - 1), cyc: 32'(acc)});
      if (with_eof && i == n - 1) begin
        len = (n > MAXLEN) ? MAXLEN : n;
        exp_s.push_back('{err: (n < 2 * MB), len_vld: 1'b1, len: 11'(len), cyc: 32'(acc)});
        last_len = len;
      end
    end
    open_frame = !with_eof;
    @(negedge iclk);
    bus.ivalid = 1'b0;
    bus.isof   = 1'b0;
    bus.ieof   = 1'b0;
  endtask

  // Bytes without a start while idle must be dropped silently.
  task automatic send_stray(input int n);
    for (int i = 0; i < n; i++) begin
      idle_gaps();
      @(negedge iclk);
      bus.ivalid = 1'b1;
      bus.idata  = 8'($urandom);
      bus.isof   = 1'b0;
      bus.ieof   = 1'($urandom);
    end
    @(negedge iclk);
    bus.ivalid = 1'b0;
    bus.ieof   = 1'b0;
  endtask

  task automatic drain_and_clear_setup();
    repeat (4) @(negedge iclk);
  endtask

  task automatic clear_queues();
    exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
  endtask

  task automatic test_reset();
    irst = 1'b1;
    bus.ivalid = 1'b0; bus.isof = 1'b0; bus.ieof = 1'b0; bus.idata = '0;
    repeat (3) @(negedge iclk);
    n_tot++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ovalid got=%b want=0", bus.ovalid);
    end
    n_tot++;
    if ({bus.odata, bus.osel, bus.olast, bus.oframe_len, bus.olen_valid, bus.oerr} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%h_%b%b_%h_%b%b want=all zero",
                        bus.odata, bus.osel, bus.olast, bus.oframe_len, bus.olen_valid, bus.oerr);
    end
    irst = 1'b0;
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_basic();
    gap_mode = 0;
    send_frame(64, 1, 0, 8'h00);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL basic_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL basic_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL basic_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    n_tot++;
    if (bus.oframe_len !== 11'(last_len)) begin n_bad++; $display("FAIL basic_len_hold got=%0d want=%0d", bus.oframe_len, last_len); end
    clear_queues();
  endtask

  task automatic test_gaps();
    gap_mode = 1;
    send_frame(64, 1, 0, 8'h00);
    gap_mode = 2;
    send_frame(40, 1, 1, 8'h00);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL gaps_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL gaps_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL gaps_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL gaps_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    clear_queues();
  endtask

  task automatic test_runt_trunc();
    gap_mode = 0;
    send_frame(8, 1, 0, 8'h80);
    send_frame(6, 1, 0, 8'h90);
    send_frame(3, 0, 0, 8'hA0);
    send_frame(20, 1, 0, 8'hC0);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL runt_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL runt_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL runt_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL runt_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    clear_queues();
  endtask

  task automatic test_saturate_single();
    gap_mode = 0;
    send_frame(3000, 1, 1, 8'h00);
    send_frame(1, 1, 0, 8'h5A);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL sat_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL sat_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL sat_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL sat_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    n_tot++;
    if (bus.oframe_len !== 11'(last_len)) begin n_bad++; $display("FAIL sat_len_hold got=%0d want=%0d", bus.oframe_len, last_len); end
    clear_queues();
  endtask

  task automatic test_reset_mid_src();
    gap_mode = 0;
    send_frame(8, 0, 0, 8'h40);
    // One more source byte is in flight when reset hits, so it never reaches the monitor.
    @(negedge iclk);
    bus.ivalid = 1'b1; bus.idata = 8'h48; bus.isof = 1'b0; bus.ieof = 1'b0;
    @(posedge iclk);
    #1;
    irst = 1'b1;
    #1;
    n_tot++;
    if ({bus.ovalid, bus.odata, bus.osel, bus.olast, bus.oframe_len, bus.olen_valid, bus.oerr} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs got=%b_%h_%b%b_%h_%b%b want=all zero", bus.ovalid,
                        bus.odata, bus.osel, bus.olast, bus.oframe_len, bus.olen_valid, bus.oerr);
    end
    open_frame = 0;
    @(negedge iclk);
    bus.ivalid = 1'b0;
    @(negedge iclk);
    irst = 1'b0;
    send_stray(5);
    send_frame(20, 1, 1, 8'h00);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL midreset_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL midreset_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL midreset_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL midreset_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    clear_queues();
  endtask

  task automatic test_random();
    gap_mode = 2;
    for (int f = 0; f < 16; f++) begin
      if (!open_frame && $urandom_range(0, 3) == 0)
        send_stray(int'($urandom_range(1, 4)));
      send_frame(int'($urandom_range(1, 80)), ($urandom_range(0, 4) != 0), 1, 8'h00);
    end
    send_frame(30, 1, 1, 8'h00);
    drain_and_clear_setup();
    n_tot++;
    if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL rand_nbytes got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    foreach (exp_b[i]) if (i < obs_b.size()) begin
      n_tot++;
      if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, obs_b[i], exp_b[i]); end
    end
    n_tot++;
    if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL rand_nstat got=%0d want=%0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_tot++;
      if (obs_s[i] !== exp_s[i]) begin n_bad++; $display("FAIL rand_stat%0d got=%h want=%h", i, obs_s[i], exp_s[i]); end
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_runt_trunc();
    test_saturate_single();
    test_reset_mid_src();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
